// File: rtl/arbiter_game_pkg.sv
// Shared phase encoding, countdown LED patterns and rotation helpers
// used by the arbiter_game score keeper.
package arbiter_game_pkg;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_CD4  = 3'd1,
      PH_CD3  = 3'd2,
      PH_CD2  = 3'd3,
      PH_CD1  = 3'd4,
      PH_WAIT = 3'd5,
      PH_WIN  = 3'd6
   } phase_e;

   localparam logic [3:0] CD4_PAT  = 4'b1111;
   localparam logic [3:0] CD3_PAT  = 4'b0111;
   localparam logic [3:0] CD2_PAT  = 4'b0011;
   localparam logic [3:0] CD1_PAT  = 4'b0001;
   localparam logic [3:0] ZERO_PAT = 4'b0000;

   localparam logic [2:0] TOGGLES_PER_STEP = 3'd4;

   function automatic logic [3:0] rotl4(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

   function automatic logic [3:0] rotr4(input logic [3:0] v);
      return {v[0], v[3:1]};
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [3:0] step_pattern(input phase_e p);
      case (p)
         PH_CD4:  return CD4_PAT;
         PH_CD3:  return CD3_PAT;
         PH_CD2:  return CD2_PAT;
         PH_CD1:  return CD1_PAT;
         default: return ZERO_PAT;
      endcase
   endfunction

   function automatic phase_e next_step(input phase_e p);
      case (p)
         PH_CD4:  return PH_CD3;
         PH_CD3:  return PH_CD2;
         PH_CD2:  return PH_CD1;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/arbiter_score_keeper_led_change_detect.sv
// Registers the LED bus once and derives the per-cycle change and
// rotation flags the score keeper decides on.
module led_change_detect
   import arbiter_game_pkg::*;
(
   input  logic       clk,
   input  logic       rst_in_n,
   input  logic [3:0] leds_in,
   output logic [3:0] prev_out,
   output logic       change_out,
   output logic       is_zero_out,
   output logic       is_onehot_out,
   output logic       rotl_match_out,
   output logic       rotr_match_out
);

   logic [3:0] prev_q;

   // One-cycle history of the LED bus.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         prev_q <= ZERO_PAT;
      end else begin
         prev_q <= leds_in;
      end
   end

   assign prev_out       = prev_q;
   assign change_out     = (prev_q != leds_in);
   assign is_zero_out    = (leds_in == ZERO_PAT);
   assign is_onehot_out  = is_onehot4(leds_in);
   assign rotl_match_out = (leds_in == rotl4(prev_q));
   assign rotr_match_out = (leds_in == rotr4(prev_q));

endmodule

// File: rtl/arbiter_score_keeper.sv
// Decodes the arbiter_game LED protocol into phases, detects the round
// winner from the rotation direction and keeps saturating win counts.
module arbiter_score_keeper
   import arbiter_game_pkg::*;
#(
   parameter int SCORE_W = 4
) (
   input  logic               clk,
   input  logic               rst_in_n,
   input  logic [3:0]         leds_in,
   output logic [2:0]         phase_out,
   output logic               winner_valid_out,
   output logic               winner_id_out,
   output logic [SCORE_W-1:0] score1_out,
   output logic [SCORE_W-1:0] score2_out,
   output logic               proto_err_out
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

   logic [3:0] prev_s;
   logic       change_s, is_zero_s, is_onehot_s, rotl_s, rotr_s;

   led_change_detect u_detect (
      .clk            (clk),
      .rst_in_n       (rst_in_n),
      .leds_in        (leds_in),
      .prev_out       (prev_s),
      .change_out     (change_s),
      .is_zero_out    (is_zero_s),
      .is_onehot_out  (is_onehot_s),
      .rotl_match_out (rotl_s),
      .rotr_match_out (rotr_s)
   );

   phase_e             state_q, state_d, nxt_state_s;
   logic [2:0]         count_q, count_d, nxt_count_s;
   logic               decided_q, decided_d, nxt_decided_s;
   logic               dir_q, dir_d, nxt_dir_s;
   logic               err_q, err_d;
   logic               valid_q, valid_d;
   logic               id_q, id_d;
   logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;

   logic       toggle_s, restart_s, error_s, dec_s, dec_id_s;
   logic [3:0] own_pat_s, next_pat_s;

   assign toggle_s   = (prev_s == ZERO_PAT) && !is_zero_s;
   assign restart_s  = toggle_s && (leds_in == CD4_PAT);
   assign own_pat_s  = step_pattern(state_q);
   assign next_pat_s = step_pattern(next_step(state_q));

   // Protocol walk: next phase, toggle count and winner decision.
   always_comb begin
      nxt_state_s   = state_q;
      nxt_count_s   = count_q;
      nxt_decided_s = decided_q;
      nxt_dir_s     = dir_q;
      error_s       = 1'b0;
      dec_s         = 1'b0;
      dec_id_s      = 1'b0;
      if (restart_s && (state_q != PH_CD4)) begin
         nxt_state_s   = PH_CD4;
         nxt_count_s   = 3'd1;
         nxt_decided_s = 1'b0;
      end else begin
         case (state_q)
            PH_IDLE: begin
               nxt_state_s = PH_IDLE;
            end
            PH_CD4, PH_CD3, PH_CD2, PH_CD1: begin
               if (leds_in == own_pat_s) begin
                  if (toggle_s && (count_q == TOGGLES_PER_STEP)) begin
                     error_s = 1'b1;
                  end else if (toggle_s) begin
                     nxt_count_s = count_q + 3'd1;
                  end else begin
                     nxt_count_s = count_q;
                  end
               end else if (is_zero_s) begin
                  // CD1 finishes once 0000 is seen on two consecutive samples.
                  if ((state_q == PH_CD1) && (count_q == TOGGLES_PER_STEP) &&
                      (prev_s == ZERO_PAT)) begin
                     nxt_state_s = PH_WAIT;
                  end else begin
                     nxt_state_s = state_q;
                  end
               end else if ((state_q != PH_CD1) && toggle_s && (leds_in == next_pat_s)) begin
                  if (count_q == TOGGLES_PER_STEP) begin
                     nxt_state_s = next_step(state_q);
                     nxt_count_s = 3'd1;
                  end else begin
                     error_s = 1'b1;
                  end
               end else begin
                  error_s = 1'b1;
               end
            end
            PH_WAIT: begin
               if (is_zero_s) begin
                  nxt_state_s = PH_WAIT;
               end else if (is_onehot_s) begin
                  nxt_state_s   = PH_WIN;
                  nxt_decided_s = 1'b0;
               end else if (leds_in != CD4_PAT) begin
                  error_s = 1'b1;
               end else begin
                  nxt_state_s = PH_WAIT;
               end
            end
            PH_WIN: begin
               if (is_zero_s) begin
                  nxt_state_s = PH_IDLE;
                  nxt_count_s = 3'd0;
                  error_s     = !decided_q;
               end else if (change_s && !decided_q) begin
                  if (rotl_s) begin
                     dec_s         = 1'b1;
                     dec_id_s      = 1'b0;
                     nxt_decided_s = 1'b1;
                     nxt_dir_s     = 1'b0;
                  end else if (rotr_s) begin
                     dec_s         = 1'b1;
                     dec_id_s      = 1'b1;
                     nxt_decided_s = 1'b1;
                     nxt_dir_s     = 1'b1;
                  end else begin
                     error_s = 1'b1;
                  end
               end else if (change_s) begin
                  error_s = dir_q ? !rotr_s : !rotl_s;
               end else begin
                  nxt_state_s = PH_WIN;
               end
            end
            default: begin
               error_s = 1'b1;
            end
         endcase
      end
   end

   // Protocol errors abort the round; a fresh 0000->1111 toggle clears the flag.
   always_comb begin
      if (error_s) begin
         state_d   = PH_IDLE;
         count_d   = 3'd0;
         decided_d = 1'b0;
         dir_d     = dir_q;
         err_d     = 1'b1;
      end else begin
         state_d   = nxt_state_s;
         count_d   = nxt_count_s;
         decided_d = nxt_decided_s;
         dir_d     = nxt_dir_s;
         err_d     = restart_s ? 1'b0 : err_q;
      end
   end

   // Winner pulse, held winner id and saturating score counters.
   always_comb begin
      valid_d  = dec_s;
      id_d     = dec_s ? dec_id_s : id_q;
      score1_d = score1_q;
      score2_d = score2_q;
      if (dec_s && !dec_id_s && (score1_q != SCORE_MAX)) begin
         score1_d = score1_q + SCORE_ONE;
      end else if (dec_s && dec_id_s && (score2_q != SCORE_MAX)) begin
         score2_d = score2_q + SCORE_ONE;
      end else begin
         score1_d = score1_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q   <= PH_IDLE;
         count_q   <= 3'd0;
         decided_q <= 1'b0;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         id_q      <= 1'b0;
         score1_q  <= '0;
         score2_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         decided_q <= decided_d;
         dir_q     <= dir_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         score1_q  <= score1_d;
         score2_q  <= score2_d;
      end
   end

   assign phase_out        = state_q;
   assign winner_valid_out = valid_q;
   assign winner_id_out    = id_q;
   assign score1_out       = score1_q;
   assign score2_out       = score2_q;
   assign proto_err_out    = err_q;

endmodule

// File: doc/arbiter_score_keeper.md
ARBITER_SCORE_KEEPER -- requirements
Module: arbiter_score_keeper

Interface
REQ-001 Parameter SCORE_W, default 4: width of each player's score counter.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_in_n  input  1  asynchronous active-low reset.
REQ-004 leds_in  input  4  arbiter_game LED bus, synchronous to clk, no synchroniser needed.
REQ-005 phase_out  output  3  decoded phase: 0 IDLE, 1 CD4, 2 CD3, 3 CD2, 4 CD1, 5 WAIT, 6 WIN.
REQ-006 winner_valid_out  output  1  one-cycle pulse when a winner is decoded.
REQ-007 winner_id_out  output  1  0 = player 1, 1 = player 2; held until the next winner_valid_out.
REQ-008 score1_out, score2_out  output  SCORE_W each  win counts, saturating at all-ones.
REQ-009 proto_err_out  output  1  sticky LED-protocol violation flag.

Function
REQ-010 leds_in is registered once (prev); a "change" is prev != leds_in; all decisions use the current sample plus prev.
REQ-011 Countdown patterns: CD4=1111, CD3=0111, CD2=0011, CD1=0001; a "toggle" is a 0000->pattern transition.
REQ-012 IDLE: toggle to 1111 -> CD4 with toggle count 1; other values ignored.
REQ-013 CDk: toggle to own pattern increments count (3-bit); 0000 and steady own pattern are legal holds.
REQ-014 CDk (k>1): toggle to next step pattern with count==4 -> next step, count 1; with count!=4 -> error.
REQ-015 CD1: entering 0000 with count==4 and holding 0000 -> WAIT; a 5th toggle of any step -> error.
REQ-016 WAIT: 0000 holds; first one-hot value -> WIN, stored as first; non-one-hot non-zero value other than 1111 -> error.
REQ-017 WIN, first change between one-hot values: new == rotate-left(old) (0001->0010->0100->1000->0001) -> player 1; new == rotate-right(old) -> player 2; any other value -> error.
REQ-018 On a decision: winner_valid_out high exactly the following cycle, winner_id_out updated in the same cycle, selected score +1 unless already all-ones.
REQ-019 Only one decision per round; later rotations in WIN are checked against the decided direction, and a mismatch -> error (score unchanged).
REQ-020 WIN: leds_in == 0000 -> IDLE; a round ending before a decision -> error, no score change.
REQ-021 Error: proto_err_out set, FSM -> IDLE.
REQ-022 proto_err_out is cleared only by reset or by a 0000->1111 toggle, which starts a new round at CD4 count 1.
REQ-023 A 0000->1111 toggle in any state other than CD4 resynchronises to CD4 count 1; in CD4 it counts per REQ-013.

Reset
REQ-024 rst_in_n low asynchronously forces: phase IDLE, count 0, prev 0000, winner_valid_out 0, winner_id_out 0, both scores 0, proto_err_out 0.
REQ-025 Reset deassertion takes effect on the first rising clk edge after release; reset mid-round discards the round and leaves no score change.

Structure
REQ-026 Shared package arbiter_game_pkg holds the phase enum, the four countdown pattern constants, and rotate-left/right helper functions.
REQ-027 One sub-module, led_change_detect, registers leds_in and outputs prev, change, is_zero, is_onehot and rotl/rotr match flags.

Verification
REQ-028 Full legal countdown (4 toggles per step) then 0000, then 0001,0010,0100,1000,0000 -> phase sequence 1..6,0, one winner_valid_out pulse, winner_id_out=0, score1=1, score2=0.
REQ-029 Same countdown, winner shift 1000,0100,0010,0001,0000 -> winner_id_out=1, score2 increments by 1, score1 unchanged.
REQ-030 CD3 shows only 3 toggles before 0011 -> proto_err_out=1, phase IDLE; then a fresh 0000->1111 -> proto_err_out=0, phase CD4.
REQ-031 In WIN, 0001 then 0100 (non-adjacent) -> proto_err_out=1, no score change, no winner_valid_out pulse.
REQ-032 Drive 16 player-1 rounds with SCORE_W=4 -> score1 saturates at 15 and winner_valid_out still pulses each round.
REQ-033 rst_in_n pulsed low asynchronously (between clk edges) during WIN before a decision -> all outputs at reset values immediately, scores 0.
